// File: rtl/qstream_pkg.sv
// Shared types and default framing constants for the Q-stream deframer.
package qstream_pkg;

  typedef enum logic [1:0] {HUNT, DATA, SYNC} qs_state_t;

  localparam int                   QS_SYNC_W   = 4;
  localparam logic [QS_SYNC_W-1:0] QS_SYNC_PAT = 4'b1011;
  localparam int                   QS_DATA_W   = 8;
  localparam int                   QS_MAX_MISS = 2;

endpackage

// File: rtl/qstream_shreg.sv
// Enable-gated MSB-first shift register with synchronous active-low clear.
// Only W-1 history bits are stored; win_o is the window that includes this cycle's incoming bit.
module qstream_shreg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] win_o
);

  logic [W-2:0] hist_q;

  assign win_o = {hist_q, d_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else if (en_i) begin
      hist_q <= win_o[W-2:0];
    end
  end

endmodule

// File: rtl/qstream_deframer.sv
// Serial deframer for topmod's Q stream: hunts for the sync pattern, then
// alternates data-word and sync-field collection with a miss-tolerant flywheel.
module qstream_deframer
  import qstream_pkg::*;
#(
  parameter int                SYNC_W   = QS_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = QS_SYNC_PAT,
  parameter int                DATA_W   = QS_DATA_W,
  parameter int                MAX_MISS = QS_MAX_MISS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              q_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  localparam int CNT_W  = $clog2(((DATA_W > SYNC_W) ? DATA_W : SYNC_W) + 1);
  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(SYNC_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(SYNC_W);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

  qs_state_t         state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [DATA_W-1:0] data_out_q;
  logic [7:0]        frame_cnt_q;
  logic              data_valid_q, locked_q, sync_err_q;

  logic              sync_en, data_en;
  logic [SYNC_W-1:0] sync_win;
  logic [DATA_W-1:0] data_win;

  assign sync_en = q_en && (state_q != DATA);
  assign data_en = q_en && (state_q == DATA);
  assign fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign miss_d  = miss_q + MISS_W'(1);

  // One window serves both hunting and in-lock sync checks; they never overlap in time.
  qstream_shreg #(.W(SYNC_W)) u_sync_sh (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (sync_en),
    .d_i   (q_in),
    .win_o (sync_win)
  );

  qstream_shreg #(.W(DATA_W)) u_data_sh (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (data_en),
    .d_i   (q_in),
    .win_o (data_win)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      fill_q       <= '0;
      miss_q       <= '0;
      data_out_q   <= '0;
      frame_cnt_q  <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (q_en) begin
        case (state_q)
          HUNT: begin
            fill_q <= fill_d;
            if (sync_win == SYNC_PAT && fill_d == FILL_FULL) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
              miss_q    <= '0;
              locked_q  <= 1'b1;
            end
          end
          DATA: begin
            if (bit_cnt_q == DATA_LAST) begin
              data_out_q   <= data_win;
              data_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
              state_q      <= SYNC;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          SYNC: begin
            if (bit_cnt_q == SYNC_LAST) begin
              bit_cnt_q <= '0;
              if (sync_win == SYNC_PAT) begin
                miss_q  <= '0;
                state_q <= DATA;
              end else if (miss_d < MISS_LIMIT) begin
                miss_q  <= miss_d;
                state_q <= DATA;
              end else begin
                sync_err_q <= 1'b1;
                locked_q   <= 1'b0;
                state_q    <= HUNT;
                fill_q     <= '0;
                miss_q     <= '0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign frame_cnt  = frame_cnt_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_qstream_deframer.sv
// Scoreboard bench for qstream_deframer: a bit-queue reference model predicts every
// cycle's outputs and pushes each expected word; a negedge monitor pops and compares.
module tb_qstream_deframer;

  localparam int SYNC_W   = 4;
  localparam int SYNC_PAT = 11;
  localparam int DATA_W   = 8;
  localparam int MAX_MISS = 2;
  localparam int M_HUNT = 0, M_DATA = 1, M_SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       q_in = 1'b0;
  logic       q_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, locked, sync_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int dvCount = 0;
  int dvMark;

  typedef struct {int data; int frame;} exp_t;
  exp_t sb[$];

  int mMode = M_HUNT;
  int mBits[$];
  int mMisses = 0;
  int expData = 0, expFrame = 0;
  bit expLocked = 0, expValid = 0, expSyncErr = 0;

  qstream_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .q_en      (q_en),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked),
    .frame_cnt (frame_cnt),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int packModel();
    int v = 0;
    foreach (mBits[i]) v = v * 2 + mBits[i];
    return v;
  endfunction

  // Reference model: collects bits into a queue and interprets whole fields at once.
  task automatic modelStep(input bit b, input bit en, input bit rstn);
    expValid   = 0;
    expSyncErr = 0;
    if (!rstn) begin
      mMode = M_HUNT; mBits.delete(); mMisses = 0;
      expData = 0; expFrame = 0; expLocked = 0;
      return;
    end
    if (!en) return;
    mBits.push_back(int'(b));
    case (mMode)
      M_HUNT: begin
        if (mBits.size() > SYNC_W) void'(mBits.pop_front());
        if (mBits.size() == SYNC_W && packModel() == SYNC_PAT) begin
          mMode = M_DATA; mBits.delete(); mMisses = 0; expLocked = 1;
        end
      end
      M_DATA: begin
        if (mBits.size() == DATA_W) begin
          expData  = packModel();
          expFrame = (expFrame + 1) % 256;
          expValid = 1;
          sb.push_back('{expData, expFrame});
          mBits.delete();
          mMode = M_SYNC;
        end
      end
      default: begin
        if (mBits.size() == SYNC_W) begin
          if (packModel() == SYNC_PAT) begin
            mMisses = 0; mMode = M_DATA;
          end else if (mMisses + 1 < MAX_MISS) begin
            mMisses++; mMode = M_DATA;
          end else begin
            expSyncErr = 1; expLocked = 0; mMisses = 0; mMode = M_HUNT;
          end
          mBits.delete();
        end
      end
    endcase
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("locked", locked, int'(expLocked));
      checkOutput("syncErr", sync_err, int'(expSyncErr));
      checkOutput("dataValid", data_valid, int'(expValid));
      checkOutput("dataOut", data_out, expData);
      checkOutput("frameCnt", frame_cnt, expFrame);
      if (data_valid === 1'b1) begin
        dvCount++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sbSpurious: got data_valid with data %0d expected no word", data_out);
        end else begin
          e = sb.pop_front();
          checkOutput("sbData", data_out, e.data);
          checkOutput("sbFrame", frame_cnt, e.frame);
        end
      end
    end
  end

  task automatic applyStimulus(input bit b, input bit en);
    q_in = b;
    q_en = en;
    @(posedge clk);
    modelStep(b, en, rst);
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(bit'(i % 2), 1'b1);
    rst = 1'b1;
  endtask

  // gapMode 0: back-to-back, 1: idle before every bit, 2: random idles
  task automatic sendWord(input int v, input int w, input int gapMode);
    for (int i = w - 1; i >= 0; i--) begin
      if (gapMode == 1) applyStimulus(bit'($urandom % 2), 1'b0);
      else if (gapMode == 2 && $urandom_range(0, 2) == 0) applyStimulus(bit'($urandom % 2), 1'b0);
      applyStimulus(bit'((v >> i) & 1), 1'b1);
    end
  endtask

  initial begin
    $display("[TB] starting qstream_deframer bench");
    doReset(2);
    #1;
    checkOutput("rstLocked", locked, 0);
    checkOutput("rstDataOut", data_out, 0);
    checkOutput("rstFrameCnt", frame_cnt, 0);
    checkOutput("rstValid", data_valid, 0);
    checkOutput("rstSyncErr", sync_err, 0);

    sendWord(SYNC_PAT, SYNC_W, 0);
    #1 checkOutput("lockAfterSync", locked, 1);
    sendWord('hC3, DATA_W, 0);
    #1;
    checkOutput("c3Data", data_out, 'hC3);
    checkOutput("c3Valid", data_valid, 1);
    checkOutput("c3Frame", frame_cnt, 1);

    doReset(2);
    dvMark = dvCount;
    sendWord(3, 2, 1);
    sendWord(SYNC_PAT, SYNC_W, 1);
    sendWord('hC3, DATA_W, 1);
    #1;
    checkOutput("gapData", data_out, 'hC3);
    checkOutput("gapFrame", frame_cnt, 1);
    checkOutput("gapValidCount", dvCount - dvMark, 1);

    sendWord(0, SYNC_W, 0);
    #1;
    checkOutput("flyLocked", locked, 1);
    checkOutput("flyNoErr", sync_err, 0);
    sendWord('h5A, DATA_W, 0);
    #1 checkOutput("flyData", data_out, 'h5A);
    sendWord(SYNC_PAT, SYNC_W, 0);
    sendWord('h3C, DATA_W, 0);
    sendWord(0, SYNC_W, 0);
    sendWord('h11, DATA_W, 0);
    sendWord(0, SYNC_W, 0);
    #1;
    checkOutput("lossSyncErr", sync_err, 1);
    checkOutput("lossLocked", locked, 0);
    dvMark = dvCount;
    sendWord('h00, DATA_W, 0);
    sendWord('hF0, DATA_W, 0);
    #1 checkOutput("lossNoValid", dvCount - dvMark, 0);
    sendWord(SYNC_PAT, SYNC_W, 0);
    sendWord('h96, DATA_W, 0);
    #1 checkOutput("relockData", data_out, 'h96);

    doReset(1);
    dvMark = dvCount;
    sendWord(SYNC_PAT, SYNC_W, 0);
    for (int k = 0; k < 256; k++) begin
      sendWord(int'($urandom % 256), DATA_W, 0);
      if (k < 255) sendWord(SYNC_PAT, SYNC_W, 0);
    end
    #1;
    checkOutput("wrapValids", dvCount - dvMark, 256);
    checkOutput("wrapFrameCnt", frame_cnt, 0);

    doReset(1);
    sendWord(SYNC_PAT, SYNC_W, 0);
    sendWord('b10110, 5, 0);
    dvMark = dvCount;
    doReset(1);
    #1;
    checkOutput("midRstLocked", locked, 0);
    checkOutput("midRstData", data_out, 0);
    sendWord(0, 3, 0);
    sendWord('h00, DATA_W, 0);
    #1 checkOutput("midRstNoValid", dvCount - dvMark, 0);
    sendWord(SYNC_PAT, SYNC_W, 0);
    sendWord('hA5, DATA_W, 0);
    #1 checkOutput("midRstRelock", data_out, 'hA5);

    doReset(1);
    for (int f = 0; f < 60; f++) begin
      sendWord(int'($urandom % 8), int'($urandom_range(0, 3)), 2);
      if ($urandom_range(0, 9) < 7) sendWord(SYNC_PAT, SYNC_W, 2);
      else sendWord(int'($urandom % 16), SYNC_W, 2);
      sendWord(int'($urandom % 256), DATA_W, 2);
    end

    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("sbEmpty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qstream_deframer.md
# qstream_deframer

Serial deframer that sits directly downstream of `topmod` and consumes its one-bit `Q` output. It hunts the bit stream for a sync pattern and then alternates data-word and sync-field collection. It presents each assembled data word with a single-cycle valid strobe. A flywheel tolerates isolated sync errors and drops lock after repeated misses.

## Interface
- `SYNC_W`, 4: sync pattern width in bits.
- `SYNC_PAT`, 4'b1011: sync pattern, MSB received first.
- `DATA_W`, 8: data bits per frame, MSB received first.
- `MAX_MISS`, 2: consecutive sync mismatches that cause loss of lock (≥1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `q_in`  in  1  serial bit, driven by `topmod` `Q`.
- `q_en`  in  1  sample enable; a bit is consumed only on cycles where `q_en`=1.
- `data_out`  out  DATA_W  last completed data word; holds its value until the next word completes.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `locked`  out  1  high in the DATA and SYNC states.
- `frame_cnt`  out  8  count of completed frames; wraps 255→0.
- `sync_err`  out  1  one-cycle pulse on loss of lock.

## Operation
- **Reset** (`rst`=0 at a clock edge): state=HUNT.
  - All outputs 0.
  - Shift registers, bit counter, fill counter and miss counter cleared.
  - Reset has priority over `q_en`.
- **Idle:** with `q_en`=0, no internal state changes; pulses deassert.
- **HUNT**
  - Each enabled bit is shifted in: `sh <= {sh[SYNC_W-2:0], q_in}`.
  - `fill` increments, saturating at SYNC_W.
  - When the post-shift `sh`==SYNC_PAT and `fill`==SYNC_W: go to DATA, `bit_cnt`=0, `miss`=0.
  - Overlapping prefixes are detected, e.g. 1,1,0,1,1 matches on the 5th bit.
- **DATA**
  - Each enabled bit shifts into the data register, MSB first.
  - On the DATA_W-th bit: `data_out` <= assembled word, `data_valid`=1, `frame_cnt`+1.
  - Then go to SYNC with `bit_cnt`=0.
- **SYNC**
  - Collect SYNC_W enabled bits.
  - On the last bit, compare with SYNC_PAT:
    - match: `miss`=0, go to DATA.
    - mismatch with `miss`+1 < MAX_MISS: `miss`+1, go to DATA (flywheel).
    - mismatch with `miss`+1 == MAX_MISS: `sync_err`=1, go to HUNT, `fill`=0, `miss`=0.
- **Loss of lock:** `locked` drops with the HUNT transition. A partially received frame is never output.
- **Width rules:**
  - `bit_cnt` width is clog2(max(DATA_W, SYNC_W)+1).
  - `frame_cnt` is plain 8-bit modular.
  - `miss` width is clog2(MAX_MISS+1).

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- `locked` rises at the edge that samples the last sync bit in HUNT.
- `data_valid`, the new `data_out` and the incremented `frame_cnt` appear at the edge that samples the last data bit. They are visible the following cycle.
- `sync_err` and the `locked` fall are simultaneous, both at the edge that samples the last bad sync bit.
- Minimum frame period is DATA_W+SYNC_W enabled bits; throughput is 1 bit per enabled cycle.
- A reset during any state takes effect at that edge. The next frame requires a full hunt.

## Structure
- Package `qstream_pkg`:
  - state enum `qs_state_t` {HUNT, DATA, SYNC};
  - default constants for SYNC_PAT, SYNC_W, DATA_W.
- Sub-module `qstream_shreg`: a parameterised enable-gated MSB-first shift register with synchronous active-low clear. Instantiate it once for the sync window and once for the data word.
- The top level holds the FSM and the counters.

## Test plan
- Hold `rst`=0 for 2 cycles with `q_in` toggling → all outputs 0; `locked`=0.
- Defaults; stream 1,0,1,1 then 1,1,0,0,0,0,1,1 with `q_en`=1 → `locked`=1 after the 4th bit. After the 12th bit: `data_out`=8'hC3, one-cycle `data_valid`, `frame_cnt`=1.
- Same stream with `q_en` low every other cycle, and false prefix 1,1 before the sync → identical outputs. The match lands on the correct bit with no spurious `data_valid`.
- Locked stream with one sync field of 0000, then a good sync and 8'h5A:
  - first bad sync: `locked` stays 1, no `sync_err`, and the 8'h5A after it is still delivered.
  - two consecutive bad syncs: `sync_err` pulses once, `locked`=0, and no further `data_valid` until a new 1011 is seen.
- 256 back-to-back good frames → `frame_cnt` returns to 0 with 256 `data_valid` pulses.
- Assert `rst`=0 after 5 data bits of a frame → outputs cleared, no `data_valid` for the partial word. The next word is output only after a full sync pattern is received.
